// File: rtl/pipelined_param_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: operation encoding,
// configuration helpers and the full-adder cell used by every carry chunk.
package pipelined_param_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit cfg_legal(input int unsigned width, input int unsigned stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Full-adder cell: returns {carry, sum}.
    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/pipelined_param_adder_if.sv
// Operand/result handshake bundle of the pipelined add/subtract unit.
interface pipelined_param_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, x, y, ci, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, x, y, ci, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/pipelined_param_adder_stage.sv
// One pipeline stage: resolves carry chunk IDX with a CHUNK-bit ripple chain and
// registers the partial sum, pending operands, chunk carry and valid bit.
module adder_pipe_stage
    import pipelined_param_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_yy,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_c,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_yy,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c,
    output logic             o_cmsb
);
    localparam int unsigned LO = IDX * CHUNK;

    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_s;
    logic [CHUNK:0]   w_c;
    logic [WIDTH-1:0] w_sum_n;

    logic             r_valid;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_yy;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_cmsb;

    assign w_a = i_x[LO +: CHUNK];
    assign w_b = i_yy[LO +: CHUNK];

    always_comb begin
        w_c     = '0;
        w_s     = '0;
        w_c[0]  = i_c;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            {w_c[i+1], w_s[i]} = fa(w_a[i], w_b[i], w_c[i]);
        end
        w_sum_n              = i_sum;
        w_sum_n[LO +: CHUNK] = w_s;
    end

    assign o_ready = !r_valid || i_ready;

    // Bubble stages keep stale data; only the valid bit is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_x     <= '0;
            r_yy    <= '0;
            r_sum   <= '0;
            r_c     <= 1'b0;
            r_cmsb  <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_x    <= i_x;
                r_yy   <= i_yy;
                r_sum  <= w_sum_n;
                r_c    <= w_c[CHUNK];
                r_cmsb <= w_c[CHUNK-1];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_x     = r_x;
    assign o_yy    = r_yy;
    assign o_sum   = r_sum;
    assign o_c     = r_c;
    assign o_cmsb  = r_cmsb;

endmodule

// File: rtl/pipelined_param_adder.sv
// Pipelined add/subtract unit: WIDTH bits resolved in STAGES registered carry
// chunks with valid/ready flow control and carry/signed-overflow flags.
module pipelined_param_adder
    import pipelined_param_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pipelined_param_adder_if.slave bus
);
    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_param_adder: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end

    logic [STAGES:0]  w_valid;
    logic [STAGES:0]  w_rdy;
    logic [STAGES:0]  w_c;
    logic [STAGES:0]  w_cmsb;
    logic [WIDTH-1:0] w_x   [STAGES+1];
    logic [WIDTH-1:0] w_yy  [STAGES+1];
    logic [WIDTH-1:0] w_sum [STAGES+1];
    logic             w_unused;

    assign w_valid[0] = bus.in_valid;
    assign w_x[0]     = bus.x;
    assign w_yy[0]    = (bus.sub == OP_SUB) ? ~bus.y : bus.y;
    assign w_c[0]     = bus.ci ^ bus.sub;
    assign w_sum[0]   = '0;
    assign w_cmsb[0]  = 1'b0;

    assign w_rdy[STAGES] = bus.out_ready;
    assign bus.in_ready  = w_rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_valid[k]),
            .o_ready (w_rdy[k]),
            .i_x     (w_x[k]),
            .i_yy    (w_yy[k]),
            .i_sum   (w_sum[k]),
            .i_c     (w_c[k]),
            .o_valid (w_valid[k+1]),
            .i_ready (w_rdy[k+1]),
            .o_x     (w_x[k+1]),
            .o_yy    (w_yy[k+1]),
            .o_sum   (w_sum[k+1]),
            .o_c     (w_c[k+1]),
            .o_cmsb  (w_cmsb[k+1])
        );
    end

    assign bus.out_valid = w_valid[STAGES];
    assign bus.s         = w_sum[STAGES];
    assign bus.cout      = w_c[STAGES];
    assign bus.ovf       = w_cmsb[STAGES] ^ w_c[STAGES];

    // Operands leaving the last stage and intermediate MSB carries have no consumer.
    assign w_unused = ^{w_x[STAGES], w_yy[STAGES], w_cmsb};

endmodule

// File: tb/tb_pipelined_param_adder.sv
// Directed-vector and stress bench for pipelined_param_adder (WIDTH=32).
module tb_pipelined_param_adder;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic clk;
    logic rst;
    logic sweep_go;
    int   checks;
    int   errors;

    pipelined_param_adder_if #(.WIDTH(32)) bus4 ();

    pipelined_param_adder #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result {ovf, cout, s} from plain integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic sb);
        logic [32:0] r;
        logic        co;
        logic        o;
        if (sb) begin
            r  = {1'b0, a} - {1'b0, b} - {32'b0, c};
            co = ~r[32];
            o  = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            r  = {1'b0, a} + {1'b0, b} + {32'b0, c};
            co = r[32];
            o  = (a[31] == b[31]) && (r[31] != a[31]);
        end
        return {o, co, r[31:0]};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int unsigned ST = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 32;
        logic done;
        pipelined_param_adder_if #(.WIDTH(32)) sif ();
        pipelined_param_adder #(.WIDTH(32), .STAGES(ST)) u_sw (
            .clk (clk),
            .rst (rst),
            .bus (sif.slave)
        );

        initial begin : sw_proc
            logic [33:0] q [$];
            logic [33:0] exp_v;
            int          lat;
            int          acc;
            int          cyc;
            bit          got;
            done          = 1'b0;
            sif.in_valid  = 1'b0;
            sif.x         = '0;
            sif.y         = '0;
            sif.ci        = 1'b0;
            sif.sub       = 1'b0;
            sif.out_ready = 1'b1;
            wait (sweep_go);
            @(posedge clk); #1;
            sif.in_valid = 1'b1;
            sif.x        = 32'h0000_1234;
            sif.y        = 32'h0000_0001;
            lat = 0;
            got = 1'b0;
            while (!got && lat < int'(ST) + 10) begin
                @(posedge clk); #1;
                sif.in_valid = 1'b0;
                lat++;
                got = sif.out_valid;
            end
            chk($sformatf("sweep%0d_latency", ST), 64'(lat), 64'(ST));
            chk($sformatf("sweep%0d_lat_s", ST), 64'(sif.s), 64'h1235);
            acc = 0;
            cyc = 0;
            while ((acc < 1000 || q.size() > 0) && cyc < 20000) begin
                @(posedge clk); #1;
                cyc++;
                sif.out_ready = ($urandom_range(3) != 0);
                sif.in_valid  = (acc < 1000) && ($urandom_range(3) != 0);
                sif.x         = $urandom;
                sif.y         = $urandom;
                sif.ci        = 1'($urandom_range(1));
                sif.sub       = 1'($urandom_range(1));
                #1;
                if (sif.in_valid && sif.in_ready) begin
                    q.push_back(model(sif.x, sif.y, sif.ci, sif.sub));
                    acc++;
                end
                if (sif.out_valid && sif.out_ready) begin
                    if (q.size() == 0) begin
                        chk($sformatf("sweep%0d_extra_beat", ST), 64'd1, 64'd0);
                    end else begin
                        exp_v = q.pop_front();
                        chk($sformatf("sweep%0d_result", ST),
                            64'({sif.ovf, sif.cout, sif.s}), 64'(exp_v));
                    end
                end
            end
            sif.in_valid = 1'b0;
            chk($sformatf("sweep%0d_drained", ST), 64'(acc == 1000 && q.size() == 0), 64'd1);
            done = 1'b1;
        end
    end

    initial begin : main
        vec_t        vecs [8];
        int          lat;
        bit          got;
        int          nacc;
        int          nout;
        int          stale;
        bit          saw_full;
        bit          prev_held;
        logic [31:0] prev_s;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0};

        checks         = 0;
        errors         = 0;
        sweep_go       = 1'b0;
        rst            = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.x         = '0;
        bus4.y         = '0;
        bus4.ci        = 1'b0;
        bus4.sub       = 1'b0;
        bus4.out_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus4.out_valid), 64'd0);
        chk("rst_s", 64'(bus4.s), 64'd0);
        chk("rst_cout", 64'(bus4.cout), 64'd0);
        chk("rst_ovf", 64'(bus4.ovf), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus4.in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus4.in_valid = 1'b1;
            bus4.x        = vecs[i].x;
            bus4.y        = vecs[i].y;
            bus4.ci       = vecs[i].ci;
            bus4.sub      = vecs[i].sub;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(bus4.in_ready), 64'd1);
            lat = 0;
            got = 1'b0;
            while (!got && lat < 20) begin
                @(posedge clk); #1;
                bus4.in_valid = 1'b0;
                lat++;
                got = bus4.out_valid;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d_s", i), 64'(bus4.s), 64'(vecs[i].s));
            chk($sformatf("vec%0d_cout", i), 64'(bus4.cout), 64'(vecs[i].cout));
            chk($sformatf("vec%0d_ovf", i), 64'(bus4.ovf), 64'(vecs[i].ovf));
        end

        // Backpressure: 8 beats back-to-back, out_ready low for cycles 3..9.
        nacc      = 0;
        nout      = 0;
        saw_full  = 1'b0;
        prev_held = 1'b0;
        prev_s    = '0;
        for (int cyc = 0; cyc < 60 && nout < 8; cyc++) begin
            @(posedge clk); #1;
            if (prev_held) begin
                chk("bp_hold_valid", 64'(bus4.out_valid), 64'd1);
                chk("bp_hold_s", 64'(bus4.s), 64'(prev_s));
            end
            bus4.out_ready = !(cyc >= 3 && cyc <= 9);
            bus4.in_valid  = (nacc < 8);
            bus4.x         = 32'(nacc);
            bus4.y         = 32'(nacc);
            bus4.ci        = 1'b0;
            bus4.sub       = 1'b0;
            #1;
            if (bus4.in_valid && !bus4.in_ready && !saw_full) begin
                saw_full = 1'b1;
                chk("bp_full_depth", 64'(nacc - nout), 64'd4);
            end
            if (bus4.in_valid && bus4.in_ready) nacc++;
            if (bus4.out_valid && bus4.out_ready) begin
                chk($sformatf("bp_s%0d", nout), 64'(bus4.s), 64'(2 * nout));
                nout++;
            end
            prev_held = bus4.out_valid && !bus4.out_ready;
            prev_s    = bus4.s;
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        chk("bp_saw_full", 64'(saw_full), 64'd1);
        chk("bp_accepted", 64'(nacc), 64'd8);
        chk("bp_emitted", 64'(nout), 64'd8);

        // Reset while three beats are in flight, none yet at the output.
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            bus4.in_valid = 1'b1;
            bus4.x        = 32'(100 + j);
            bus4.y        = 32'h1;
            #1;
            chk($sformatf("rm_in_ready%0d", j), 64'(bus4.in_ready), 64'd1);
            @(posedge clk); #1;
        end
        chk("rm_no_output_yet", 64'(bus4.out_valid), 64'd0);
        bus4.x = 32'hDEAD_BEEF;
        rst    = 1'b1;
        #1;
        chk("rm_out_valid", 64'(bus4.out_valid), 64'd0);
        chk("rm_s", 64'(bus4.s), 64'd0);
        @(posedge clk); #2;
        rst           = 1'b0;
        bus4.in_valid = 1'b0;
        #1;
        chk("rm_in_ready_after", 64'(bus4.in_ready), 64'd1);
        stale = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus4.out_valid) stale++;
        end
        chk("rm_no_stale", 64'(stale), 64'd0);

        sweep_go = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 30000 && !got; k++) begin
            @(posedge clk);
            got = g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done;
        end
        chk("sweep_complete", 64'(got), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
